// File: rtl/serial_prog_loader.sv
// Framed byte-stream program loader (SYNC, START, COUNT, payload [, CHK with SERIAL_PROG_LOADER_CHECKSUM_EN]) driving a RAM write port.
// Latency: payload byte -> ram_we one cycle later; no backpressure, every rx_valid byte is consumed.
module serial_prog_loader #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_COUNT,
    ST_DATA,
    ST_CHK
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  cpu_hold_q;
  logic                  busy_q;
  logic                  load_done_q;
  logic                  load_error_q;
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] chk_total_d;
`endif

  logic [CW-1:0]         span_end_d;
  logic                  start_bad_d;
  logic                  count_bad_d;
  logic                  last_byte_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;

  // Range check on the whole frame up front, so the write address can never wrap.
  always_comb begin
    span_end_d  = CW'(start_q) + {1'b0, rx_data};
    start_bad_d = |rx_data[DATA_WIDTH-1:ADDR_WIDTH];
    count_bad_d = (rx_data == '0) || (span_end_d > CW'(DEPTH));
    last_byte_d = (({1'b0, idx_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == cnt_q);
    wr_addr_d   = start_q + idx_q;
  end

`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
  assign chk_total_d = sum_q + rx_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      ram_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      if (rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_q      <= ST_START;
              busy_q       <= 1'b1;
              cpu_hold_q   <= 1'b1;
              load_error_q <= 1'b0;
            end
          end
          ST_START: begin
            if (start_bad_d) begin
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              start_q <= rx_data[ADDR_WIDTH-1:0];
              state_q <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (count_bad_d) begin
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              cnt_q   <= rx_data[ADDR_WIDTH:0];
              idx_q   <= '0;
              state_q <= ST_DATA;
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
              sum_q   <= '0;
`endif
            end
          end
          ST_DATA: begin
            // SYNC_BYTE inside the payload is ordinary data.
            ram_we_q    <= 1'b1;
            ram_addr_q  <= wr_addr_d;
            ram_wdata_q <= rx_data;
            idx_q       <= idx_q + 1'b1;
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_q + rx_data;
            if (last_byte_d) begin
              state_q <= ST_CHK;
            end
`else
            if (last_byte_d) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end
`endif
          end
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
          ST_CHK: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (chk_total_d == '0) begin
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              load_error_q <= 1'b1;
            end
          end
`endif
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_serial_prog_loader.sv
// Scoreboard bench for serial_prog_loader: frame-level reference model pushes expected
// writes/done/error events with their cycle; a negedge monitor pops and compares.
module tb_serial_prog_loader;

  localparam int DEPTH = 16;
  localparam int SYNC  = 8'hA5;
`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int EV_W = 0;
  localparam int EV_D = 1;
  localparam int EV_E = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_error;

  serial_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   hold_exp = 0;
  int   err_exp = 0;
  int   exp_ram[DEPTH];
  int   dut_ram[DEPTH];
  int   pay[DEPTH];
  ev_t  exp_q[$];
  ev_t  ev;
  logic err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic fail_now(input string name, input int act);
    total_cnt++;
    $display("FAIL %s: unexpected event, value %0d at cycle %0d", name, act, cyc);
  endtask

  task automatic push_ev(input int kind, input int addr, input int data, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: acts as the RAM and checks every DUT-initiated event against the scoreboard.
  always @(negedge clk) begin
    if (ram_we) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_W) fail_now("unexpected_write", int'(ram_addr));
      else begin
        ev = exp_q.pop_front();
        chk("wr_addr", int'(ram_addr), ev.addr);
        chk("wr_data", int'(ram_wdata), ev.data);
        chk("wr_cycle", cyc, ev.cyc);
      end
      dut_ram[ram_addr] = int'(ram_wdata);
    end
    if (load_done) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_D) fail_now("unexpected_done", cyc);
      else begin
        ev = exp_q.pop_front();
        chk("done_cycle", cyc, ev.cyc);
        chk("done_hold_low", int'(cpu_hold), 0);
        chk("done_with_we", int'(ram_we), CHK_EN ? 0 : 1);
      end
    end
    if (load_error && !err_prev) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_E) fail_now("unexpected_error", cyc);
      else begin
        ev = exp_q.pop_front();
        chk("error_cycle", cyc, ev.cyc);
      end
    end
    err_prev = load_error;
  end

  task automatic send_byte(input int b, input int gap, input bit chk_busy, output int c);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    if (chk_busy) chk("busy_in_frame", int'(busy), 1);
    rx_valid = 1'b1;
    rx_data  = 8'(b);
    c = cyc;
  endtask

  // Reference model: the outcome of a frame follows directly from its fields.
  task automatic send_frame(input int st, input int cn, input int delta, input int gmax,
                            input int abort);
    int c;
    int sum;
    int ck;
    send_byte(SYNC, $urandom_range(0, gmax), 1'b0, c);
    hold_exp = 1;
    err_exp  = 0;
    send_byte(st, $urandom_range(0, gmax), 1'b1, c);
    if (st >= DEPTH) begin
      push_ev(EV_E, 0, 0, c + 1);
      err_exp = 1;
      return;
    end
    send_byte(cn, $urandom_range(0, gmax), 1'b0, c);
    if (cn == 0 || st + cn > DEPTH) begin
      push_ev(EV_E, 0, 0, c + 1);
      err_exp = 1;
      return;
    end
    sum = 0;
    for (int i = 0; i < cn; i++) begin
      if (i == abort) return;
      send_byte(pay[i], $urandom_range(0, gmax), 1'b0, c);
      push_ev(EV_W, st + i, pay[i], c + 1);
      exp_ram[st + i] = pay[i];
      sum += pay[i];
    end
    if (CHK_EN) begin
      ck = (256 - (sum % 256) + delta) % 256;
      send_byte(ck, $urandom_range(0, gmax), 1'b0, c);
      if ((sum + ck) % 256 == 0) begin
        push_ev(EV_D, 0, 0, c + 1);
        hold_exp = 0;
      end else begin
        push_ev(EV_E, 0, 0, c + 1);
        err_exp = 1;
      end
    end else begin
      push_ev(EV_D, 0, 0, c + 1);
      hold_exp = 0;
    end
  endtask

  task automatic post_check(input string tag);
    repeat (3) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    chk({tag, "_hold"}, int'(cpu_hold), hold_exp);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_error"}, int'(load_error), err_exp);
    chk({tag, "_done_idle"}, int'(load_done), 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic send_junk(input int n);
    int b;
    int c;
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 255);
      if (b == SYNC) b = 8'h5A;
      send_byte(b, $urandom_range(0, 1), 1'b0, c);
    end
  endtask

  initial begin
    int kind;
    int st;
    int cn;
    int gm;
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      exp_ram[i] = 0;
      dut_ram[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    chk("rst_hold", int'(cpu_hold), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_error", int'(load_error), 0);
    reset = 1'b0;

    // LDI/HLT image
    pay[0] = 8'h88; pay[1] = 8'hFF;
    send_frame(0, 2, 0, 0, -1);
    post_check("t1");

    send_junk(0);
    begin
      int c;
      send_byte(8'h12, 0, 1'b0, c);
      send_byte(8'h34, 0, 1'b0, c);
    end
    pay[0] = 8'h3C; pay[1] = 8'h01; pay[2] = 8'hC3;
    send_frame(5, 3, 0, 1, -1);
    post_check("t2");

    send_frame(8'h0E, 3, 0, 0, -1);
    post_check("t3");

    pay[0] = SYNC; pay[1] = SYNC; pay[2] = SYNC;
    send_frame(0, 3, 0, 0, -1);
    post_check("t4");

`ifdef SERIAL_PROG_LOADER_CHECKSUM_EN
    pay[0] = 8'h10;
    send_frame(3, 1, 8'h10, 0, -1);
    post_check("t5_bad");
    pay[0] = 8'h77; pay[1] = 8'h21;
    send_frame(6, 2, 0, 0, -1);
    post_check("t5_good");
`endif

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_frame(8, 4, 0, 0, 2);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("abort_we", int'(ram_we), 0);
    chk("abort_addr", int'(ram_addr), 0);
    chk("abort_wdata", int'(ram_wdata), 0);
    chk("abort_hold", int'(cpu_hold), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(load_done), 0);
    chk("abort_error", int'(load_error), 0);
    reset    = 1'b0;
    hold_exp = 0;
    err_exp  = 0;
    post_check("t6");

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) send_junk($urandom_range(1, 3));
      kind = $urandom_range(0, 5);
      gm   = $urandom_range(0, 2);
      st   = $urandom_range(0, DEPTH - 1);
      cn   = $urandom_range(1, DEPTH - st);
      for (int i = 0; i < DEPTH; i++)
        pay[i] = ($urandom_range(0, 3) == 0) ? SYNC : $urandom_range(0, 255);
      case (kind)
        3: send_frame($urandom_range(DEPTH, 255), cn, 0, gm, -1);
        4: send_frame(st, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH - st + 1, 255),
                      0, gm, -1);
        5: send_frame(st, cn, $urandom_range(1, 255), gm, -1);
        default: send_frame(st, cn, 0, gm, -1);
      endcase
      post_check("rand");
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("final_drained", exp_q.size(), 0);
    for (int i = 0; i < DEPTH; i++) chk("ram_image", dut_ram[i], exp_ram[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
